uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO: the next generation of the fixed 8N1 serialiser. It accepts words from the host on a start/ready handshake and buffers up to FIFO_DEPTH of them. It serialises each word as start, data (LSB first), optional parity and 1 or 2 stop bits. It sits between on-chip logic and the board's serial TX pin and replaces the single-byte transmitter in new designs.

## Interface
- CLKS_PER_BIT, 434: clock cycles per serial bit; legal ≥ 2.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: words buffered; power of 2, ≥ 2.
- iCLOCK  in  1  system clock, all logic on rising edge.
- iNRESET  in  1  asynchronous, active-low reset.
- iTXSTART  in  1  write strobe; word accepted on an edge where iTXSTART=1 and oTXREADY=1.
- iTXDATA  in  DATA_BITS  word to transmit, sampled with iTXSTART.
- oTXREADY  out  1  1 when the FIFO is not full.
- oTX  out  1  serial line, idle high.
- oTXBUSY  out  1  1 when the FSM is not IDLE or the FIFO is non-empty.
- oTXDONE  out  1  one-cycle pulse at the end of each frame.
- oFIFOCOUNT  out  $clog2(FIFO_DEPTH+1)  words currently in the FIFO.

## Operation
- **Reset (async, iNRESET=0):** oTX=1, oTXBUSY=0, oTXDONE=0, oTXREADY=1, oFIFOCOUNT=0. FIFO pointers are cleared, FSM=IDLE, bit and baud counters are 0.
- **FIFO:** circular buffer with wrapping read/write pointers.
  - A write when full is ignored, even if a pop happens in the same cycle; no data is corrupted.
  - A simultaneous accepted write and pop leaves the count unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** oTX=1. If the FIFO is non-empty, pop the head into the shift register, compute the parity bit, and go to START.
- **START:** oTX=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** oTX = shift register bit 0 for CLKS_PER_BIT cycles per bit, shifting right each bit. After DATA_BITS bits, go to PARITY if PARITY≠0, else go to STOP.
- **PARITY:** oTX = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = inverted XOR of the data bits.
- **STOP:** oTX=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - In the last cycle, oTXDONE=1.
  - If the FIFO is non-empty in that cycle, pop and go directly to START (back-to-back, no idle bit); otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1, wraps, and advances the bit counter on wrap.
- **Width of bit-count register:** $clog2(DATA_BITS+1).
- **Reset mid-frame:** oTX goes high immediately, the frame is aborted, no oTXDONE is produced, and buffered words are discarded.
- iTXDATA is captured into the FIFO at acceptance; later changes on iTXDATA have no effect.

## Timing
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Latency from an idle, empty state:
  - iTXSTART accepted at edge k, so oFIFOCOUNT=1 after edge k.
  - Pop at edge k+1.
  - oTX falls after edge k+2.
- oTXREADY is registered; it falls in the cycle after the write that fills the FIFO and rises in the cycle after the pop that frees a slot.
- oTXDONE is high for exactly one cycle per frame, coincident with the last stop-bit cycle.
- In back-to-back operation, the next start bit begins in the cycle after oTXDONE.
- oTXBUSY falls in the cycle after the final oTXDONE, when the FIFO is empty. It rises in the cycle after the first accepted write.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **8N1, single word:** CLKS_PER_BIT=4; write 0x55 when idle.
  - oTX low at edge k+2 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles.
  - oTXDONE pulses once, at cycle k+41.
- **Even and odd parity:** PARITY=2, write 0x07 → parity bit 1 (3 ones). PARITY=1, same word → parity bit 0. Frame length 11×CLKS_PER_BIT.
- **Back-to-back:** FIFO_DEPTH=4; write 0xA1, 0xB2, 0xC3 on consecutive cycles.
  - oFIFOCOUNT peaks at 2.
  - Three contiguous frames with no idle gap; three oTXDONE pulses spaced 40 cycles apart (CLKS_PER_BIT=4).
  - oTXBUSY high throughout.
- **Overflow:** with a frame in progress, write 5 words.
  - oTXREADY=0 once count=4; the 5th write is dropped.
  - Exactly 5 frames are sent (the in-flight word plus 4 queued), all with correct data.
- **Reset mid-frame:** assert iNRESET=0 during DATA with 2 words queued.
  - oTX=1 immediately; oFIFOCOUNT=0, oTXBUSY=0, oTXREADY=1; no oTXDONE.
  - After release, a fresh 0x3C transmits correctly.
- **2 stop bits, DATA_BITS=7:** write 7'h41 → stop high for 2×CLKS_PER_BIT cycles; frame length 10×CLKS_PER_BIT.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter with an integrated transmit FIFO. Host words are
//            accepted on an iTXSTART/oTXREADY handshake, buffered in a
//            circular FIFO and serialised as start, data (LSB first), optional
//            parity and 1 or 2 stop bits. Frames are sent back-to-back while
//            the FIFO holds data.
// Ports    : iCLOCK      system clock (rising edge)
//            iNRESET     asynchronous active-low reset
//            iTXSTART    write strobe, accepted when oTXREADY=1
//            iTXDATA     word to transmit, captured at acceptance
//            oTXREADY    FIFO not full (registered)
//            oTX         serial line, idle high (registered)
//            oTXBUSY     transmitter active or FIFO non-empty (registered)
//            oTXDONE     one-cycle pulse in the last stop-bit cycle
//            oFIFOCOUNT  words currently held in the FIFO
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                 iCLOCK,
    input  logic                                 iNRESET,
    input  logic                                 iTXSTART,
    input  logic [DATA_BITS-1:0]                 iTXDATA,
    output logic                                 oTXREADY,
    output logic                                 oTX,
    output logic                                 oTXBUSY,
    output logic                                 oTXDONE,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      oFIFOCOUNT
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH+1);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_BITS+1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_ready;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_done;
    logic                 r_busy;

    logic                 w_wr;
    logic                 w_pop;
    logic                 w_baud_wrap;
    logic                 w_stop_last;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic                 w_tx_nxt;

    // r_ready is zero whenever the FIFO is full, so a write on a full FIFO is
    // dropped even if a pop frees a slot on the same edge.
    assign w_wr        = iTXSTART & r_ready;
    assign w_baud_wrap = (r_baud == c_BAUD_W'(CLKS_PER_BIT-1));
    assign w_stop_last = (r_state == c_STOP) && w_baud_wrap &&
                         (r_bit_cnt == c_BIT_W'(STOP_BITS-1));
    assign w_pop       = (r_count != '0) &&
                         ((r_state == c_IDLE) || w_stop_last);
    assign w_count_nxt = r_count + c_CNT_W'(w_wr) - c_CNT_W'(w_pop);

    assign w_head      = r_mem[r_rptr];
    // Odd parity inverts the XOR so the total number of ones becomes odd.
    assign w_head_par  = (PARITY == 1) ? ~(^w_head) : (^w_head);

    always_ff @(posedge iCLOCK) begin
        if (w_wr) begin
            r_mem[r_wptr] <= iTXDATA;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge iCLOCK or negedge iNRESET) begin
        if (!iNRESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_CNT_W'(FIFO_DEPTH));
        end
    end

    // Line level for the state currently held; registered below, so oTX
    // trails the state register by one cycle.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            c_START:  w_tx_nxt = 1'b0;
            c_DATA:   w_tx_nxt = r_shift[0];
            c_PARITY: w_tx_nxt = r_par;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge iNRESET) begin
        if (!iNRESET) begin
            r_state   <= c_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_done <= w_stop_last;
            r_busy <= (r_state != c_IDLE) || (r_count != '0) || w_wr;

            case (r_state)
                c_IDLE: begin
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= w_head_par;
                        r_state <= c_START;
                    end
                end

                c_START: begin
                    if (w_baud_wrap) begin
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= c_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                c_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == c_BIT_W'(DATA_BITS-1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? c_PARITY : c_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                c_PARITY: begin
                    if (w_baud_wrap) begin
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= c_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                c_STOP: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_bit_cnt == c_BIT_W'(STOP_BITS-1)) begin
                            r_bit_cnt <= '0;
                            // Back-to-back: load the next word straight
                            // into START with no idle bit in between.
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= w_head_par;
                                r_state <= c_START;
                            end else begin
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state   <= c_IDLE;
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign oTX        = r_tx;
    assign oTXDONE    = r_done;
    assign oTXBUSY    = r_busy;
    assign oTXREADY   = r_ready;
    assign oFIFOCOUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench. Four transmitter configurations (8N1,
//            8E1, 8O1, 7N2; CLKS_PER_BIT=4, FIFO_DEPTH=4) share one stimulus
//            stream. Each has a frame-level reference model: a word queue
//            plus the edge at which each word left the FIFO, from which the
//            expected line level, done pulse, busy, ready and count follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int NCFG  = 4;

    function automatic int cfg_db(input int i);
        return (i == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [8:0]           din;
    logic [NCFG-1:0]      tx_v;
    logic [NCFG-1:0]      done_v;
    logic [NCFG-1:0]      ready_v;
    logic [NCFG-1:0]      busy_v;
    logic [NCFG-1:0][2:0] cnt_v;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DB    = cfg_db(g);
        localparam int PAR   = cfg_par(g);
        localparam int SB    = cfg_stop(g);
        localparam int FRAME = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * C;
        localparam logic [8:0] MASK = 9'((1 << DB) - 1);

        uart_tx_fifo #(
            .CLKS_PER_BIT (C),
            .DATA_BITS    (DB),
            .PARITY       (PAR),
            .STOP_BITS    (SB),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .iCLOCK     (clk),
            .iNRESET    (rst_n),
            .iTXSTART   (start),
            .iTXDATA    (din[DB-1:0]),
            .oTXREADY   (ready_v[g]),
            .oTX        (tx_v[g]),
            .oTXBUSY    (busy_v[g]),
            .oTXDONE    (done_v[g]),
            .oFIFOCOUNT (cnt_v[g])
        );

        // Line level at offset j (in clock cycles) inside the frame of w.
        function automatic logic frame_bit(input logic [8:0] w, input int j);
            int  idx;
            logic p;
            idx = j / C;
            if (idx == 0) return 1'b0;
            if (idx <= DB) return w[idx-1];
            if ((PAR != 0) && (idx == DB + 1)) begin
                p = 1'b0;
                for (int i = 0; i < DB; i++) p ^= w[i];
                return (PAR == 2) ? p : ~p;
            end
            return 1'b1;
        endfunction

        // A word popped at edge p drives the line on the cycles after edges
        // p+1 .. p+FRAME; the next pop may happen no earlier than p+FRAME.
        int         t;
        int         lp, pp;
        logic [8:0] lw, pw;
        logic [8:0] q[$];
        int         cnt_pre, j;
        bit         wr, pop, sbusy, etx, edone;

        initial begin
            t = 0; lp = -100000; pp = -100000; lw = '0; pw = '0;
            forever begin
                @(negedge clk);
                t++;
                if (!rst_n) begin
                    q.delete();
                    lp = -100000; pp = -100000;
                    check($sformatf("cfg%0d_rst_tx@%0d", g, t),    tx_v[g], 1);
                    check($sformatf("cfg%0d_rst_done@%0d", g, t),  done_v[g], 0);
                    check($sformatf("cfg%0d_rst_busy@%0d", g, t),  busy_v[g], 0);
                    check($sformatf("cfg%0d_rst_ready@%0d", g, t), ready_v[g], 1);
                    check($sformatf("cfg%0d_rst_cnt@%0d", g, t),   cnt_v[g], 0);
                end else begin
                    cnt_pre = q.size();
                    wr      = start && (cnt_pre < DEPTH);
                    sbusy   = (t - 1 >= lp) && (t - 1 <= lp + FRAME - 1);
                    pop     = (cnt_pre != 0) && (t >= lp + FRAME);
                    if (pop) begin
                        pp = lp; pw = lw;
                        lp = t;  lw = q.pop_front();
                    end
                    if (wr) q.push_back(din & MASK);
                    etx = 1'b1; edone = 1'b0;
                    j = t - 1 - lp;
                    if (j >= 0 && j < FRAME) begin
                        etx = frame_bit(lw, j);
                        if (j == FRAME - 1) edone = 1'b1;
                    end
                    j = t - 1 - pp;
                    if (j >= 0 && j < FRAME) begin
                        etx = frame_bit(pw, j);
                        if (j == FRAME - 1) edone = 1'b1;
                    end
                    check($sformatf("cfg%0d_tx@%0d", g, t),    tx_v[g], etx);
                    check($sformatf("cfg%0d_done@%0d", g, t),  done_v[g], edone);
                    check($sformatf("cfg%0d_busy@%0d", g, t),  busy_v[g],
                          (wr || cnt_pre != 0 || sbusy) ? 1 : 0);
                    check($sformatf("cfg%0d_cnt@%0d", g, t),   cnt_v[g], q.size());
                    check($sformatf("cfg%0d_ready@%0d", g, t), ready_v[g],
                          (q.size() != DEPTH) ? 1 : 0);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One word from idle. f0 is the hand-written 10-bit 8N1 frame (bit 0 =
    // start) for cfg0; p1/p2 are the even/odd parity bits for cfg1/cfg2.
    task automatic single(input logic [8:0] data, input logic [9:0] f0,
                          input bit p1, input bit p2);
        int nd[NCFG];
        int dn[NCFG];
        for (int i = 0; i < NCFG; i++) begin nd[i] = 0; dn[i] = -1; end
        step();
        start = 1'b1;
        din   = data;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            for (int i = 0; i < NCFG; i++) begin
                if (done_v[i]) begin nd[i]++; dn[i] = n; end
            end
            if (n == 1) check("lit_idle_before_start", tx_v[0], 1);
            if (n >= 4 && (n % 4) == 0 && n <= 40)
                check($sformatf("lit_8n1_bit%0d", (n - 4) / 4), tx_v[0], f0[(n - 4) / 4]);
            if (n == 40) begin
                check("lit_even_parity_bit", tx_v[1], p1);
                check("lit_odd_parity_bit",  tx_v[2], p2);
            end
            if (n == 36 || n == 40) check("lit_7n2_stop_high", tx_v[3], 1);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < NCFG; i++) check($sformatf("lit_done_count_cfg%0d", i), nd[i], 1);
        check("lit_done_cycle_8n1",  dn[0], 41);
        check("lit_done_cycle_8e1",  dn[1], 45);
        check("lit_done_cycle_8o1",  dn[2], 45);
        check("lit_done_cycle_7n2",  dn[3], 41);
    endtask

    initial begin
        int dt[$];
        int maxc, allbusy, nd;
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (3) step();
        check("lit_reset_tx",    tx_v, 15);
        check("lit_reset_ready", ready_v, 15);
        rst_n = 1'b1;
        repeat (3) step();

        // Single frames with hand-computed line patterns.
        single(9'h055, 10'h2AA, 1'b0, 1'b1);
        single(9'h007, 10'h20E, 1'b1, 1'b0);

        // Back-to-back: three writes on consecutive edges.
        step();
        start = 1'b1; din = 9'h0A1;
        maxc = 0; allbusy = 1; dt.delete();
        for (int n = 0; n < 160; n++) begin
            @(negedge clk);
            if (int'(cnt_v[0]) > maxc) maxc = int'(cnt_v[0]);
            if (done_v[0]) dt.push_back(n);
            if (n <= 121 && !busy_v[0]) allbusy = 0;
            if (n == 122) check("lit_b2b_busy_falls", busy_v[0], 0);
            #1;
            if (n == 0) din = 9'h0B2;
            if (n == 1) din = 9'h0C3;
            if (n == 2) start = 1'b0;
        end
        check("lit_b2b_count_peak", maxc, 2);
        check("lit_b2b_busy_high", allbusy, 1);
        check("lit_b2b_done_count", dt.size(), 3);
        if (dt.size() == 3) begin
            check("lit_b2b_first_done", dt[0], 41);
            check("lit_b2b_spacing1", dt[1] - dt[0], 40);
            check("lit_b2b_spacing2", dt[2] - dt[1], 40);
        end

        // Overflow: one frame in flight, then five writes on a depth-4 FIFO.
        step();
        start = 1'b1; din = 9'($urandom);
        nd = 0;
        for (int n = 0; n < 260; n++) begin
            @(negedge clk);
            if (done_v[0]) nd++;
            if (n == 13) begin
                check("lit_ovf_count_full", cnt_v[0], 4);
                check("lit_ovf_ready_low",  ready_v[0], 0);
            end
            if (n == 14) check("lit_ovf_fifth_dropped", cnt_v[0], 4);
            #1;
            if (n == 0) start = 1'b0;
            if (n >= 9 && n <= 13) begin start = 1'b1; din = 9'($urandom); end
            if (n == 14) start = 1'b0;
        end
        check("lit_ovf_frames_sent", nd, 5);

        // Reset during DATA with two words queued.
        step();
        start = 1'b1; din = 9'($urandom);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            if (n == 0) din = 9'($urandom);
            if (n == 1) din = 9'($urandom);
            if (n == 2) start = 1'b0;
        end
        check("lit_pre_reset_count", cnt_v[0], 2);
        rst_n = 1'b0;
        #1;
        check("lit_midrst_tx",    tx_v, 15);
        check("lit_midrst_cnt",   cnt_v, 0);
        check("lit_midrst_busy",  busy_v, 0);
        check("lit_midrst_ready", ready_v, 15);
        check("lit_midrst_done",  done_v, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        single(9'h03C, 10'h278, 1'b0, 1'b1);

        // Random traffic, frequently overrunning the FIFO.
        for (int i = 0; i < 600; i++) begin
            step();
            start = ($urandom_range(0, 2) == 0);
            din   = 9'($urandom);
        end
        step();
        start = 1'b0;
        repeat (300) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
